// File: rtl/win_checker.sv
// win_checker: end-of-move board scanner for the 8x8 connect game.
//
// After the placement block pulses start, the whole board is read back from
// board RAM one row per cycle into a local row buffer. The buffer is then
// scanned in a single cycle for a run of WIN_LEN cells belonging to the player
// who just moved (horizontal, vertical, both diagonals) and for a full board.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   start    one-cycle request; ignored while busy
//   player   cell code of the player who just moved, sampled with start
//   rd_en    board RAM read enable
//   rd_addr  board RAM row address
//   rd_data  row word from board RAM, valid the cycle after rd_en;
//            cell c occupies bits [2c+1:2c]
//   busy     check in progress
//   done     one-cycle pulse, results valid from this cycle on
//   win      captured player owns a run of WIN_LEN cells
//   winner   captured player when win, else 0
//   draw     board has no empty cell and win is 0
module win_checker #(
    parameter int unsigned ROWS    = 8,
    parameter int unsigned COLS    = 8,
    parameter int unsigned WIN_LEN = 4,
    localparam int unsigned AddrW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            player,
    output logic                  rd_en,
    output logic [AddrW-1:0]      rd_addr,
    input  logic [2*COLS-1:0]     rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  win,
    output logic [1:0]            winner,
    output logic                  draw
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StLast,
        StEval,
        StDone
    } state_e;

    state_e                state_q;
    logic [AddrW-1:0]      cnt_q;
    logic [1:0]            player_q;
    logic                  rd_en_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  win_q;
    logic [1:0]            winner_q;
    logic                  draw_q;
    logic [2*COLS-1:0]     row_buf_q [ROWS];

    logic                  hit;
    logic                  run;
    logic                  full;
    logic                  win_d;

    // Window scan over the captured board. Each window starts assumed-matching
    // and is knocked out by any cell that differs from the latched player.
    always_comb begin
        hit  = 1'b0;
        run  = 1'b0;
        full = 1'b1;

        for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
                if (row_buf_q[r][2*c +: 2] == 2'd0) full = 1'b0;
            end
        end

        // Horizontal
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int c = 0; c <= int'(COLS) - int'(WIN_LEN); c++) begin
                run = 1'b1;
                for (int k = 0; k < int'(WIN_LEN); k++) begin
                    if (row_buf_q[r][2*(c+k) +: 2] != player_q) run = 1'b0;
                end
                hit = hit | run;
            end
        end

        // Vertical
        for (int r = 0; r <= int'(ROWS) - int'(WIN_LEN); r++) begin
            for (int c = 0; c < int'(COLS); c++) begin
                run = 1'b1;
                for (int k = 0; k < int'(WIN_LEN); k++) begin
                    if (row_buf_q[r+k][2*c +: 2] != player_q) run = 1'b0;
                end
                hit = hit | run;
            end
        end

        // Down-right diagonal
        for (int r = 0; r <= int'(ROWS) - int'(WIN_LEN); r++) begin
            for (int c = 0; c <= int'(COLS) - int'(WIN_LEN); c++) begin
                run = 1'b1;
                for (int k = 0; k < int'(WIN_LEN); k++) begin
                    if (row_buf_q[r+k][2*(c+k) +: 2] != player_q) run = 1'b0;
                end
                hit = hit | run;
            end
        end

        // Down-left diagonal, anchored at its rightmost (top) cell
        for (int r = 0; r <= int'(ROWS) - int'(WIN_LEN); r++) begin
            for (int c = int'(WIN_LEN) - 1; c < int'(COLS); c++) begin
                run = 1'b1;
                for (int k = 0; k < int'(WIN_LEN); k++) begin
                    if (row_buf_q[r+k][2*(c-k) +: 2] != player_q) run = 1'b0;
                end
                hit = hit | run;
            end
        end

        // Codes 0 and 3 are not players; without this an empty board would
        // "win" for player 0.
        win_d = hit & ((player_q == 2'd1) | (player_q == 2'd2));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            player_q <= 2'd0;
            rd_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            win_q    <= 1'b0;
            winner_q <= 2'd0;
            draw_q   <= 1'b0;
            for (int r = 0; r < int'(ROWS); r++) begin
                row_buf_q[r] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        player_q <= player;
                        win_q    <= 1'b0;
                        winner_q <= 2'd0;
                        draw_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        rd_en_q  <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= StRead;
                    end
                end
                StRead: begin
                    // Data for address cnt-1 arrives while cnt is issued.
                    if (cnt_q != '0) row_buf_q[cnt_q - 1'b1] <= rd_data;
                    if (cnt_q == AddrW'(ROWS - 1)) begin
                        rd_en_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StLast;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StLast: begin
                    row_buf_q[ROWS-1] <= rd_data;
                    state_q           <= StEval;
                end
                StEval: begin
                    win_q    <= win_d;
                    winner_q <= win_d ? player_q : 2'd0;
                    draw_q   <= ~win_d & full;
                    done_q   <= 1'b1;
                    state_q  <= StDone;
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rd_en   = rd_en_q;
    assign rd_addr = cnt_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign win     = win_q;
    assign winner  = winner_q;
    assign draw    = draw_q;

endmodule

// File: tb/tb_win_checker.sv
module tb_win_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  player;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic        win;
    logic [1:0]  winner;
    logic        draw;

    logic [15:0] mem [8];

    typedef struct packed {
        logic       win;
        logic [1:0] winner;
        logic       draw;
    } res_t;

    res_t  exp_q[$];
    int    tests = 0;
    int    fails = 0;
    string cur_name = "reset";

    // Boards are written {row7, ..., row0}.
    localparam logic [127:0] Empty = 128'h0;
    // Rows alternate in pairs; strict per-row alternation of 6666/9999 would
    // put same-code runs on every down-right diagonal.
    localparam logic [127:0] FullNoRun =
        {16'h9999, 16'h9999, 16'h6666, 16'h6666, 16'h9999, 16'h9999, 16'h6666, 16'h6666};

    win_checker #(
        .ROWS    (8),
        .COLS    (8),
        .WIN_LEN (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .player  (player),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .win     (win),
        .winner  (winner),
        .draw    (draw)
    );

    always #5 clk = ~clk;

    // Board RAM with one-cycle registered read.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s/%s: got %0h expected %0h", cur_name, name, act, exp);
        end
    endtask

    // Monitor: every done pulse pops one expected result.
    always @(negedge clk) begin
        res_t e;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL %s/unexpected_done: got done=1 expected no done", cur_name);
            end else begin
                e = exp_q.pop_front();
                check("win", {31'd0, win}, {31'd0, e.win});
                check("winner", {30'd0, winner}, {30'd0, e.winner});
                check("draw", {31'd0, draw}, {31'd0, e.draw});
            end
        end
    end

    task automatic set_board(input logic [127:0] b);
        for (int r = 0; r < 8; r++) mem[r] = b[16*r +: 16];
    endtask

    // Returns at the negedge of cycle T+1 (T = edge that sampled start).
    task automatic fire(input logic [1:0] p);
        @(negedge clk);
        player = p;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_result();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s/timeout: got no done expected done within 40 cycles", cur_name);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run(input string name, input logic [127:0] b, input logic [1:0] p,
                       input logic w, input logic [1:0] wn, input logic d);
        cur_name = name;
        set_board(b);
        exp_q.push_back(res_t'({w, wn, d}));
        fire(p);
        wait_result();
    endtask

    task automatic check_quiet(input string name);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_rd_en"}, {31'd0, rd_en}, 32'd0);
        check({name, "_rd_addr"}, {29'd0, rd_addr}, 32'd0);
        check({name, "_done"}, {31'd0, done}, 32'd0);
        check({name, "_results"}, {28'd0, win, winner, draw}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        player = 2'd0;
        set_board(Empty);
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;
        @(negedge clk);

        // 1: empty board, detailed cycle timing
        cur_name = "empty_timing";
        set_board(Empty);
        exp_q.push_back(res_t'({1'b0, 2'd0, 1'b0}));
        fire(2'd1);
        for (int k = 1; k <= 12; k++) begin
            check($sformatf("rd_en_T%0d", k), {31'd0, rd_en}, (k <= 8) ? 32'd1 : 32'd0);
            if (k <= 8) check($sformatf("rd_addr_T%0d", k), {29'd0, rd_addr}, k - 1);
            check($sformatf("busy_T%0d", k), {31'd0, busy}, (k <= 11) ? 32'd1 : 32'd0);
            check($sformatf("done_T%0d", k), {31'd0, done}, (k == 11) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        wait_result();

        // 2: horizontal run, then same board for the opponent
        run("row5_p1", {16'h0, 16'h0, 16'h0055, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
            2'd1, 1'b1, 2'd1, 1'b0);
        repeat (5) @(negedge clk);
        check("win_held", {31'd0, win}, 32'd1);
        cur_name = "row5_p2";
        set_board({16'h0, 16'h0, 16'h0055, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0});
        exp_q.push_back(res_t'({1'b0, 2'd0, 1'b0}));
        fire(2'd2);
        check("win_cleared_on_start", {31'd0, win}, 32'd0);
        wait_result();

        // 3: vertical and both diagonals
        run("col6_p2", {16'h0, 16'h0, 16'h2000, 16'h2000, 16'h2000, 16'h2000, 16'h0, 16'h0},
            2'd2, 1'b1, 2'd2, 1'b0);
        run("diag_dr_p1", {16'h0, 16'h0, 16'h0, 16'h0, 16'h0040, 16'h0010, 16'h0004, 16'h0001},
            2'd1, 1'b1, 2'd1, 1'b0);
        run("diag_dl_p2", {16'h0, 16'h0, 16'h0, 16'h0, 16'h0200, 16'h0800, 16'h2000, 16'h8000},
            2'd2, 1'b1, 2'd2, 1'b0);
        run("row7_run8_p1", {16'h5555, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
            2'd1, 1'b1, 2'd1, 1'b0);

        // 4: full boards
        run("full_norun_p1", FullNoRun, 2'd1, 1'b0, 2'd0, 1'b1);
        run("full_norun_p2", FullNoRun, 2'd2, 1'b0, 2'd0, 1'b1);
        run("full_pair_p1", {FullNoRun[127:16], 16'h6665}, 2'd1, 1'b0, 2'd0, 1'b1);
        run("one_empty_p1", {16'h9998, FullNoRun[111:0]}, 2'd1, 1'b0, 2'd0, 1'b0);
        run("full_win_p1", {FullNoRun[127:80], 16'h5555, FullNoRun[63:0]},
            2'd1, 1'b1, 2'd1, 1'b0);

        // Non-player codes never win
        run("empty_p0", Empty, 2'd0, 1'b0, 2'd0, 1'b0);
        run("threes_p3", {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h00FF},
            2'd3, 1'b0, 2'd0, 1'b0);

        // 6: short run and a run that wraps across rows
        run("run3_p1", {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0015},
            2'd1, 1'b0, 2'd0, 1'b0);
        run("wrap_p1", {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0005, 16'h5000},
            2'd1, 1'b0, 2'd0, 1'b0);

        // 5: extra starts are ignored
        cur_name = "extra_starts";
        set_board({16'h0, 16'h0, 16'h0055, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0});
        exp_q.push_back(res_t'({1'b1, 2'd1, 1'b0}));
        fire(2'd1);                       // now in T+1
        repeat (2) @(negedge clk);        // T+3
        player = 2'd2;
        start  = 1'b1;
        @(negedge clk);                   // T+4
        start  = 1'b0;
        repeat (7) @(negedge clk);        // T+11
        start  = 1'b1;
        @(negedge clk);                   // T+12
        start  = 1'b0;
        check("busy_T12", {31'd0, busy}, 32'd0);
        wait_result();
        repeat (15) @(negedge clk);
        check("idle_after_extras", {31'd0, busy}, 32'd0);

        // 5: reset mid-check abandons the run
        cur_name = "mid_reset";
        fire(2'd1);                       // T+1
        repeat (4) @(negedge clk);        // T+5
        rst = 1'b1;
        @(negedge clk);                   // T+6
        check_quiet("after_reset");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("no_restart", {31'd0, busy}, 32'd0);
        run("fresh_after_reset", {16'h0, 16'h0, 16'h0055, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
            2'd1, 1'b1, 2'd1, 1'b0);

        // start coincident with reset: reset wins
        cur_name = "start_with_rst";
        @(negedge clk);
        rst    = 1'b1;
        start  = 1'b1;
        player = 2'd1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check_quiet("start_rst");
        repeat (15) @(negedge clk);
        check("start_rst_idle", {31'd0, busy}, 32'd0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
